// File: rtl/ro_pair_comparator.sv
// Ring-oscillator PUF counting side: selects two ROs from the challenge, counts their
// synchronized rising edges over a fixed window and reports which one ran faster.
module ro_pair_comparator #(
    parameter int CNT_W  = 16,
    parameter int WINDOW = 1000,
    parameter int SETTLE = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [7:0]       challenge_i,
    input  logic             ro1_i,
    input  logic             ro2_i,
    output logic [3:0]       sel1_o,
    output logic [3:0]       sel2_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             response_o,
    output logic             tie_o,
    output logic             sat_o,
    output logic [CNT_W-1:0] count1_o,
    output logic [CNT_W-1:0] count2_o
);

    localparam int TMAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0]    SETTLE_LAST = TW'(SETTLE);
    localparam logic [TW-1:0]    WINDOW_LAST = TW'(WINDOW - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    typedef enum logic [2:0] {
        IDLE,
        SETTLING,
        COUNTING,
        COMPARING,
        FINISHED
    } state_t;

    state_t           state;
    logic [TW-1:0]    timer;
    logic [2:0]       ro1_sync;
    logic [2:0]       ro2_sync;
    logic [CNT_W-1:0] cnt1;
    logic [CNT_W-1:0] cnt2;
    logic             sat;
    logic             rise1;
    logic             rise2;

    // Sync chain is s1=[0], s2=[1], s3=[2]; an edge is seen when s2 rises above s3.
    assign rise1 = ro1_sync[1] & ~ro1_sync[2];
    assign rise2 = ro2_sync[1] & ~ro2_sync[2];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            timer      <= '0;
            ro1_sync   <= '0;
            ro2_sync   <= '0;
            cnt1       <= '0;
            cnt2       <= '0;
            sat        <= 1'b0;
            sel1_o     <= '0;
            sel2_o     <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            response_o <= 1'b0;
            tie_o      <= 1'b0;
            sat_o      <= 1'b0;
            count1_o   <= '0;
            count2_o   <= '0;
        end else begin
            ro1_sync <= {ro1_sync[1:0], ro1_i};
            ro2_sync <= {ro2_sync[1:0], ro2_i};
            done_o   <= 1'b0;

            case (state)
                IDLE: begin
                    if (start_i) begin
                        sel1_o <= challenge_i[7:4];
                        sel2_o <= challenge_i[3:0];
                        cnt1   <= '0;
                        cnt2   <= '0;
                        sat    <= 1'b0;
                        timer  <= '0;
                        busy_o <= 1'b1;
                        state  <= SETTLING;
                    end
                end

                // The acceptance cycle only loads the new select, so settling
                // runs SETTLE further cycles after it (timer 0..SETTLE).
                SETTLING: begin
                    if (timer == SETTLE_LAST) begin
                        timer <= '0;
                        state <= COUNTING;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                COUNTING: begin
                    if (rise1) begin
                        if (cnt1 == CNT_MAX) sat <= 1'b1;
                        else                 cnt1 <= cnt1 + 1'b1;
                    end
                    if (rise2) begin
                        if (cnt2 == CNT_MAX) sat <= 1'b1;
                        else                 cnt2 <= cnt2 + 1'b1;
                    end
                    if (timer == WINDOW_LAST) begin
                        timer <= '0;
                        state <= COMPARING;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                COMPARING: begin
                    response_o <= (cnt1 > cnt2);
                    tie_o      <= (cnt1 == cnt2);
                    sat_o      <= sat;
                    count1_o   <= cnt1;
                    count2_o   <= cnt2;
                    busy_o     <= 1'b0;
                    done_o     <= 1'b1;
                    state      <= FINISHED;
                end

                FINISHED: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
